// File: rtl/ring_eject_unit.sv
// Ring NoC local ejection stage: filters, buffers and times flits addressed to this node.
// Latency: flit on flit_in at edge N is visible on pe_* in cycle N+1; pop at edge N shows next head in N+1.
// Backpressure: none toward the router (full FIFO drops); valid/ready toward the PE holds head stable until taken.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   node_addr           - this node's address (static after reset)
//   cur_cycle           - global cycle counter used to compute latency
//   flit_in             - router local output, sampled every cycle (bit 63 = valid)
//   pe_valid/pe_ready   - head handshake toward the PE; pe_data/pe_latency carry the head
//   fifo_full           - FIFO holds DEPTH entries
//   rx_count, drop_count, misroute_count, lat_max - saturating statistics
module ring_eject_unit #(
  parameter int ADDR_W = 4,
  parameter int FLIT_W = 64,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] node_addr,
  input  logic [TS_W-1:0]   cur_cycle,
  input  logic [FLIT_W-1:0] flit_in,
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic [FLIT_W-1:0] pe_data,
  output logic [TS_W-1:0]   pe_latency,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  misroute_count,
  output logic [TS_W-1:0]   lat_max
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] data_mem [DEPTH];
  logic [TS_W-1:0]   lat_mem  [DEPTH];

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        misroute;
  logic        flit_vld;
  logic        dst_hit;
  logic [3:0]  flit_dst;
  logic [31:0] flit_ts;
  logic [TS_W-1:0] latency;

  assign flit_vld = flit_in[63];
  assign flit_dst = flit_in[58:55];
  assign flit_ts  = flit_in[54:23];
  assign dst_hit  = (ADDR_W'(flit_dst) == node_addr);

  // Modular subtraction: a timestamp that wrapped past zero still yields the small true latency.
  assign latency = cur_cycle - TS_W'(flit_ts);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop      = !empty && pe_ready;
  // A pop in the same cycle frees the slot the incoming flit needs, so full+pop still accepts.
  assign push     = flit_vld && dst_hit && (!full || pop);
  assign drop     = flit_vld && dst_hit && full && !pop;
  assign misroute = flit_vld && !dst_hit;

  assign pe_valid   = !empty;
  assign fifo_full  = full;
  // Head outputs read zero while empty so reset and drained states present clean data.
  assign pe_data    = empty ? '0 : data_mem[rd_ptr[AW-1:0]];
  assign pe_latency = empty ? '0 : lat_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem[wr_ptr[AW-1:0]] <= flit_in;
      lat_mem[wr_ptr[AW-1:0]]  <= latency;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rx_count       <= '0;
      drop_count     <= '0;
      misroute_count <= '0;
      lat_max        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (push && rx_count != '1) begin
        rx_count <= rx_count + CNT_W'(1);
      end
      if (drop && drop_count != '1) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      if (misroute && misroute_count != '1) begin
        misroute_count <= misroute_count + CNT_W'(1);
      end
      if (push && latency > lat_max) begin
        lat_max <= latency;
      end
    end
  end

endmodule
